// File: rtl/bram_pingpong_sched_if.sv
// Capture-side and consumer-side signal bundle for the ping-pong BRAM
// write scheduler. The slave modport is the scheduler itself; the
// master modport is whoever drives the ADC strobes and acknowledges
// finished banks.
interface bram_pingpong_sched_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              en;
   logic              sinc;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic              en_a;
   logic              en_b;
   logic [3:0]        we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rdy;
   logic              rd_bank;
   logic [ADDR_W:0]   rd_len;
   logic              rd_ack;
   logic              overrun;
   logic [7:0]        drop_cnt;
   logic [15:0]       sweep_cnt;

   modport slave (
      input  en, sinc, sample_valid, sample_data, rd_ack,
      output en_a, en_b, we, wr_addr, wr_data,
             rdy, rd_bank, rd_len, overrun, drop_cnt, sweep_cnt
   );

   modport master (
      output en, sinc, sample_valid, sample_data, rd_ack,
      input  en_a, en_b, we, wr_addr, wr_data,
             rdy, rd_bank, rd_len, overrun, drop_cnt, sweep_cnt
   );
endinterface

// File: rtl/bram_pingpong_sched.sv
// Ping-pong BRAM write scheduler: captures one sweep of ADC samples per
// sinc window into alternating banks A/B, hands finished banks to a
// consumer in fill order and drops whole sweeps when both banks are
// still waiting to be read.
module bram_pingpong_sched #(
   parameter int ADDR_W    = 12,
   parameter int N_SAMPLES = 4000,
   parameter int DATA_W    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bram_pingpong_sched_if.slave  bus
);

   localparam logic [ADDR_W:0] N_LEN    = (ADDR_W+1)'(N_SAMPLES);
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N_SAMPLES - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE, SKIP} state_t;

   state_t            state;
   state_t            state_nx;

   logic              sinc_d;
   logic              rise;
   logic              fall;
   logic              wr_bank;
   logic              rd_ptr;
   logic [1:0]        full;
   logic [ADDR_W:0]   len_a;
   logic [ADDR_W:0]   len_b;
   logic [ADDR_W:0]   count;
   logic              rdy_int;
   logic              ack_ok;
   logic              free_wr;

   logic              accept;
   logic              mark;
   logic              start;
   logic              drop;

   logic [3:0]        we_p1;
   logic              en_a_p1;
   logic              en_b_p1;
   logic              last_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [DATA_W-1:0] data_p1;

   logic              overrun;
   logic [7:0]        drop_cnt;
   logic [15:0]       sweep_cnt;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign rise    = bus.sinc & ~sinc_d;
   assign fall    = ~bus.sinc & sinc_d;
   assign rdy_int = |full;
   assign ack_ok  = bus.rd_ack & rdy_int;
   // An ack that frees the bank we are about to write wins over a drop.
   assign free_wr = ack_ok & (rd_ptr == wr_bank);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and per-cycle capture decisions.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      mark     = 1'b0;
      start    = 1'b0;
      drop     = 1'b0;
      case (state)
         IDLE: begin
            if (rise && bus.en) begin
               if (full[wr_bank] && !free_wr) begin
                  state_nx = SKIP;
                  drop     = 1'b1;
               end else begin
                  state_nx = CAPTURE;
                  start    = 1'b1;
               end
            end
         end
         CAPTURE: begin
            // The bank is closed only after its last write has issued, so a
            // strobe never lands on a bank that is already flagged full.
            mark   = last_p1 | (fall & (count != '0));
            accept = bus.sample_valid & ~fall & (count < N_LEN);
            if (fall)         state_nx = IDLE;
            else if (last_p1) state_nx = DONE;
         end
         DONE, SKIP: begin
            if (!bus.sinc) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Write stage: one cycle after an accepted strobe drive the BRAM port.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_p1   <= 4'h0;
         en_a_p1 <= 1'b0;
         en_b_p1 <= 1'b0;
         last_p1 <= 1'b0;
         addr_p1 <= '0;
         data_p1 <= '0;
         count   <= '0;
         sinc_d  <= 1'b0;
      end else begin
         sinc_d  <= bus.sinc;
         we_p1   <= accept ? 4'hF : 4'h0;
         en_a_p1 <= accept & ~wr_bank;
         en_b_p1 <= accept & wr_bank;
         last_p1 <= accept && (count == LAST_IDX);
         if (accept) begin
            addr_p1 <= count[ADDR_W-1:0];
            data_p1 <= bus.sample_data;
         end
         if (start)       count <= '0;
         else if (accept) count <= count + (ADDR_W+1)'(1);
      end
   end

   // Bank bookkeeping: full flags, lengths, fill/read pointers, statistics.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full      <= 2'b00;
         len_a     <= '0;
         len_b     <= '0;
         wr_bank   <= 1'b0;
         rd_ptr    <= 1'b0;
         overrun   <= 1'b0;
         drop_cnt  <= 8'd0;
         sweep_cnt <= 16'd0;
      end else begin
         if (drop) begin
            overrun  <= 1'b1;
            drop_cnt <= sat_inc8(drop_cnt);
         end
         if (ack_ok) begin
            full[rd_ptr] <= 1'b0;
            rd_ptr       <= ~rd_ptr;
         end
         if (mark) begin
            full[wr_bank] <= 1'b1;
            if (wr_bank) len_b <= count;
            else         len_a <= count;
            wr_bank   <= ~wr_bank;
            sweep_cnt <= sweep_cnt + 16'd1;
         end
      end
   end

   assign bus.en_a      = en_a_p1;
   assign bus.en_b      = en_b_p1;
   assign bus.we        = we_p1;
   assign bus.wr_addr   = addr_p1;
   assign bus.wr_data   = data_p1;
   assign bus.rdy       = rdy_int;
   assign bus.rd_bank   = rd_ptr;
   assign bus.rd_len    = !rdy_int ? '0 : (rd_ptr ? len_b : len_a);
   assign bus.overrun   = overrun;
   assign bus.drop_cnt  = drop_cnt;
   assign bus.sweep_cnt = sweep_cnt;

endmodule
